fetch_prefetch: RTL

Parametrised instruction-fetch front end that replaces the single-word, zero-latency fetch stage. It issues in-order read requests to instruction memory over a request/grant port that tolerates variable latency. Returned words go into a prefetch buffer and are presented downstream as a valid/ready stream, tagged with their PC. A branch redirect flushes the buffer and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_prefetch_if.sv | 23 ++
 rtl/fetch_fifo.sv | 39 +++
 rtl/fetch_prefetch.sv | 59 +++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared reset PC and buffer-entry width helper for the fetch front end
package fetch_pkg;
  localparam int RESET_PC = 0;
  function automatic int entry_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction
endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: fetch-side bus (pc, mem req/gnt/rvalid/rdata, word stream valid/ready, branch redirect); master = fetch unit, slave = environment
interface fetch_prefetch_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic [ADDR_W-1:0] pc;
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_gnt;
  logic mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic word_valid;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] word_pc;
  logic word_ready;
  logic [ADDR_W-1:0] branch_wr;
  logic branch_wr_en;
  modport master (
    output pc, mem_req, mem_addr, word_valid, word, word_pc,
    input mem_gnt, mem_rvalid, mem_rdata, word_ready, branch_wr, branch_wr_en
  );
  modport slave (
    input pc, mem_req, mem_addr, word_valid, word, word_pc,
    output mem_gnt, mem_rvalid, mem_rdata, word_ready, branch_wr, branch_wr_en
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of DEPTH W-bit entries; ports clk, rst, push/pop/flush (flush wins), din, head (0 when empty), count, empty, full
module fetch_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign head = empty ? '0 : mem[rd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
    if (!rst && !flush) assert (!(push && full && !pop)) else $error("fetch_fifo overflow");
  end
endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: credit-limited in-order instruction prefetcher; ports clk, sync_rst, bus (master: pc, mem req/gnt/rvalid/rdata, word valid/ready/pc, branch redirect)
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic sync_rst,
  fetch_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_w(ADDR_W, DATA_W);
  logic [ADDR_W-1:0] pc, rsp_pc;
  logic [CW-1:0] inflight, drop, count;
  logic [EW-1:0] head;
  logic empty, full, accept, push, pop;
  assign bus.mem_req = !sync_rst && !bus.branch_wr_en && ({1'b0, inflight} + {1'b0, count} < (CW+1)'(DEPTH));
  assign accept = bus.mem_req && bus.mem_gnt;
  assign push = bus.mem_rvalid && drop == '0 && !bus.branch_wr_en;
  assign pop = !empty && bus.word_ready;
  assign bus.pc = pc;
  assign bus.mem_addr = pc;
  assign bus.word_valid = !empty;
  assign {bus.word_pc, bus.word} = head;
  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(sync_rst),
    .push(push),
    .pop(pop),
    .flush(bus.branch_wr_en),
    .din({rsp_pc, bus.mem_rdata}),
    .head(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pc <= ADDR_W'(RESET_PC);
      rsp_pc <= ADDR_W'(RESET_PC);
      inflight <= '0;
      drop <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(bus.mem_rvalid);
      if (bus.branch_wr_en) begin
        pc <= bus.branch_wr;
        rsp_pc <= bus.branch_wr;
        drop <= inflight - CW'(bus.mem_rvalid);
      end else begin
        if (accept) pc <= pc + 1'b1;
        if (bus.mem_rvalid && drop != '0) drop <= drop - 1'b1;
        if (push) rsp_pc <= rsp_pc + 1'b1;
      end
    end
    if (!sync_rst) assert (!(bus.mem_rvalid && inflight == '0)) else $error("mem_rvalid with nothing in flight");
  end
endmodule
